// File: rtl/window_magnitude.sv
// Windowed peak-to-peak amplitude, midpoint DC offset and rising-crossing count for an ADC stream.
// Optional crossing detector built only when WINDOW_MAGNITUDE_FREQ_EN is defined.
module window_magnitude #(
  parameter int unsigned WIDTH          = 12,
  parameter int unsigned WINDOW_SAMPLES = 50000000,
  parameter int unsigned HYST           = 16,
  parameter int unsigned CNT_W          = $clog2(WINDOW_SAMPLES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] amp,
  output logic [WIDTH-1:0] dc_offset,
  output logic [CNT_W-1:0] crossings,
  output logic             res_valid,
  output logic             have_result
);

  localparam int unsigned IDX_W = $clog2(WINDOW_SAMPLES);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WINDOW_SAMPLES - 1);

  logic [WIDTH-1:0] max_q, min_q;
  logic [WIDTH-1:0] max_nx, min_nx;
  logic [IDX_W-1:0] cnt_q;
  logic             last;
  logic [WIDTH:0]   sum;

  // Trackers updated with the current sample so the final sample is included in results.
  assign max_nx = (sample > max_q) ? sample : max_q;
  assign min_nx = (sample < min_q) ? sample : min_q;
  assign last   = sample_valid && (cnt_q == LastIdx);
  assign sum    = {1'b0, max_nx} + {1'b0, min_nx};

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q       <= '0;
      min_q       <= '1;
      cnt_q       <= '0;
      amp         <= '0;
      dc_offset   <= '0;
      res_valid   <= 1'b0;
      have_result <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (clear) begin
        max_q <= '0;
        min_q <= '1;
        cnt_q <= '0;
      end else if (sample_valid) begin
        if (last) begin
          amp         <= max_nx - min_nx;
          dc_offset   <= sum[WIDTH:1];
          res_valid   <= 1'b1;
          have_result <= 1'b1;
          max_q       <= '0;
          min_q       <= '1;
          cnt_q       <= '0;
        end else begin
          max_q <= max_nx;
          min_q <= min_nx;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef WINDOW_MAGNITUDE_FREQ_EN
  logic [WIDTH-1:0] thr_q;
  logic [WIDTH-1:0] thr_lo, thr_hi;
  logic [WIDTH:0]   hi_sum;
  logic             armed_q, armed_nx;
  logic [CNT_W-1:0] xcnt_q, xcnt_nx;
  logic [CNT_W-1:0] crossings_q;

  // Hysteresis band clamped to the sample range instead of wrapping.
  assign thr_lo = (thr_q >= WIDTH'(HYST)) ? thr_q - WIDTH'(HYST) : '0;
  assign hi_sum = {1'b0, thr_q} + (WIDTH + 1)'(HYST);
  assign thr_hi = hi_sum[WIDTH] ? '1 : hi_sum[WIDTH-1:0];

  always_comb begin
    armed_nx = armed_q;
    xcnt_nx  = xcnt_q;
    if (!armed_q) begin
      if (sample < thr_lo) armed_nx = 1'b1;
    end else if (sample >= thr_hi) begin
      armed_nx = 1'b0;
      if (xcnt_q != '1) xcnt_nx = xcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q       <= {1'b1, {(WIDTH - 1){1'b0}}};
      armed_q     <= 1'b0;
      xcnt_q      <= '0;
      crossings_q <= '0;
    end else if (clear) begin
      armed_q <= 1'b0;
      xcnt_q  <= '0;
    end else if (sample_valid) begin
      // Arm state deliberately carries across window boundaries.
      armed_q <= armed_nx;
      if (last) begin
        xcnt_q      <= '0;
        crossings_q <= xcnt_nx;
        thr_q       <= sum[WIDTH:1];
      end else begin
        xcnt_q <= xcnt_nx;
      end
    end
  end

  assign crossings = crossings_q;
`else
  assign crossings = '0;
`endif

endmodule

// File: tb/tb_window_magnitude.sv
// Directed scoreboard bench for window_magnitude (WIDTH=12, WINDOW_SAMPLES=8, HYST=16).
module tb_window_magnitude;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned WS    = 8;
  localparam int unsigned HYST  = 16;
  localparam int unsigned CNT_W = $clog2(WS) + 1;
`ifdef WINDOW_MAGNITUDE_FREQ_EN
  localparam bit FREQ = 1'b1;
`else
  localparam bit FREQ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sample = '0;
  logic             sample_valid = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] amp, dc_offset;
  logic [CNT_W-1:0] crossings;
  logic             res_valid, have_result;

  window_magnitude #(
    .WIDTH(WIDTH), .WINDOW_SAMPLES(WS), .HYST(HYST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid), .clear(clear),
    .amp(amp), .dc_offset(dc_offset), .crossings(crossings),
    .res_valid(res_valid), .have_result(have_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned amp;
    int unsigned dc;
    int unsigned cr;
  } res_t;

  res_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pulse  = 0;
  bit   mon_en   = 1'b0;
  int unsigned held_amp = 0, held_dc = 0, held_cr = 0, held_have = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Results compared when the DUT pulses; held values compared on every other cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (res_valid) begin
        n_pulse++;
        if (q.size() == 0) begin
          chk("unexpected_res_valid", 32'(res_valid), 32'd0);
        end else begin
          res_t e;
          e = q.pop_front();
          chk("amp", 32'(amp), e.amp);
          chk("dc_offset", 32'(dc_offset), e.dc);
          chk("crossings", 32'(crossings), e.cr);
          chk("have_result", 32'(have_result), 32'd1);
          held_amp  = e.amp;
          held_dc   = e.dc;
          held_cr   = e.cr;
          held_have = 1;
        end
      end else begin
        chk("hold_amp", 32'(amp), held_amp);
        chk("hold_dc", 32'(dc_offset), held_dc);
        chk("hold_crossings", 32'(crossings), held_cr);
        chk("hold_have_result", 32'(have_result), held_have);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned s);
    sample       = WIDTH'(s);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    sample       = '0;
  endtask

  task automatic push(input int unsigned a, input int unsigned d, input int unsigned c);
    res_t r;
    r.amp = a;
    r.dc  = d;
    r.cr  = c;
    q.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    held_amp  = 0;
    held_dc   = 0;
    held_cr   = 0;
    held_have = 0;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    tick();
    do_reset();
    mon_en = 1'b1;
    chk("rst_amp", 32'(amp), 32'd0);
    chk("rst_dc", 32'(dc_offset), 32'd0);
    chk("rst_crossings", 32'(crossings), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_have_result", 32'(have_result), 32'd0);

    // Ramp every cycle
    p0 = n_pulse;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push(700, 450, 0);
      send(i * 100);
    end
    drain("ramp_drain");
    tick();
    chk("ramp_pulses", 32'(n_pulse - p0), 32'd1);

    // Same ramp, valid every third cycle, junk on idle cycles
    do_reset();
    p0 = n_pulse;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push(700, 450, 0);
      send(i * 100);
      sample = 12'hfff;
      tick();
      tick();
    end
    drain("sparse_drain");
    tick();
    chk("sparse_pulses", 32'(n_pulse - p0), 32'd1);

    // Full-scale alternating samples
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(4095, 2047, FREQ ? 4 : 0);
      send((i % 2 == 1) ? 4095 : 0);
    end
    drain("alt_drain");

    // clear coincident with the final sample
    do_reset();
    p0 = n_pulse;
    for (int i = 0; i < 7; i++) send(1000);
    sample       = 12'd1000;
    sample_valid = 1'b1;
    clear        = 1'b1;
    tick();
    clear        = 1'b0;
    sample_valid = 1'b0;
    tick();
    tick();
    chk("clear_no_pulse", 32'(n_pulse - p0), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(0, 500, 0);
      send(500);
    end
    drain("clear_drain");

    // Reset mid-window discards partial data
    for (int i = 0; i < 5; i++) send(4000);
    do_reset();
    chk("midrst_amp", 32'(amp), 32'd0);
    chk("midrst_dc", 32'(dc_offset), 32'd0);
    chk("midrst_have", 32'(have_result), 32'd0);
    p0 = n_pulse;
    for (int i = 1; i <= 7; i++) send(i * 100);
    tick();
    tick();
    chk("midrst_no_early", 32'(n_pulse - p0), 32'd0);
    push(700, 450, 0);
    send(800);
    drain("midrst_drain");

    // Two windows exercising the crossing detector
    do_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 7) push(700, 450, (FREQ && w == 1) ? 2 : 0);
        send((i % 4 < 2) ? 100 : 800);
      end
    end
    drain("xing_drain");

    tick();
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
